// File: rtl/sort_stream_ctrl.sv
// sort_stream_ctrl: valid/ready sequencer in front of the sort core.
// Ports: clk, rst (async, active-high), start/busy/done/timeout_err;
//   s_* input stream, m_* output stream (m_last on element N);
//   core_* drive/observe the sort core (rst, din, now1, now2,
//   y_valid, dout). Define SORT_STREAM_PERF_EN to add the
//   perf_cycles busy-cycle counter port.
module sort_stream_ctrl #(
  parameter int LOG_INPUT_NUM  = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  core_rst,
  output logic [DATA_WIDTH-1:0] core_din,
  output logic                  core_now1,
  output logic                  core_now2,
  input  logic                  core_y_valid,
  input  logic [DATA_WIDTH-1:0] core_dout
`ifdef SORT_STREAM_PERF_EN
  ,
  output logic [31:0]           perf_cycles
`endif
);

  localparam int N  = 1 << LOG_INPUT_NUM;
  localparam int CW = LOG_INPUT_NUM + 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ?
                      $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CRST, S_LOAD, S_WAIT,
    S_CAP, S_SEND, S_ADV, S_ERR
  } state_t;

  state_t                state_q, state_d;
  logic                  crst_q, crst_d;
  logic [CW-1:0]         ld_cnt_q, ld_cnt_d;
  logic [CW-1:0]         out_cnt_q, out_cnt_d;
  logic [TW-1:0]         wait_cnt_q, wait_cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  s_ready_q, s_ready_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic                  core_rst_q, core_rst_d;
  logic [DATA_WIDTH-1:0] core_din_q, core_din_d;
  logic                  now1_q, now1_d;
  logic                  now2_q, now2_d;
`ifdef SORT_STREAM_PERF_EN
  logic [31:0]           perf_q, perf_d;
`endif

  always_comb begin
    state_d    = state_q;
    crst_d     = crst_q;
    ld_cnt_d   = ld_cnt_q;
    out_cnt_d  = out_cnt_q;
    wait_cnt_d = wait_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    s_ready_d  = s_ready_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    core_rst_d = core_rst_q;
    core_din_d = core_din_q;
    now1_d     = 1'b0;
    now2_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d      = 1'b0;
          crst_d     = 1'b0;
          ld_cnt_d   = '0;
          out_cnt_d  = '0;
          wait_cnt_d = '0;
          busy_d     = 1'b1;
          core_rst_d = 1'b1;
          state_d    = S_CRST;
        end
      end
      S_CRST: begin
        // crst_q marks the second of the two core reset cycles
        if (crst_q) begin
          core_rst_d = 1'b0;
          s_ready_d  = 1'b1;
          state_d    = S_LOAD;
        end else begin
          crst_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (s_valid && s_ready_q) begin
          core_din_d = s_data;
          now1_d     = 1'b1;
          ld_cnt_d   = ld_cnt_q + 1'b1;
          if (ld_cnt_q == CW'(N - 1)) begin
            s_ready_d  = 1'b0;
            wait_cnt_d = '0;
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (core_y_valid) begin
          state_d = S_CAP;
        end else if (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d      = 1'b1;
          core_rst_d = 1'b1;
          state_d    = S_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_CAP: begin
        m_data_d  = core_dout;
        m_last_d  = (out_cnt_q == CW'(N - 1));
        m_valid_d = 1'b1;
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          out_cnt_d = out_cnt_q + 1'b1;
          if (m_last_q) begin
            done_d     = 1'b1;
            busy_d     = 1'b0;
            core_rst_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            now2_d  = 1'b1;
            state_d = S_ADV;
          end
        end
      end
      S_ADV: begin
        state_d = S_CAP;
      end
      S_ERR: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef SORT_STREAM_PERF_EN
  always_comb begin
    perf_d = perf_q;
    if (state_q == S_IDLE && start) begin
      perf_d = '0;
    end else if (busy_q && perf_q != 32'hFFFF_FFFF) begin
      perf_d = perf_q + 32'd1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      crst_q     <= 1'b0;
      ld_cnt_q   <= '0;
      out_cnt_q  <= '0;
      wait_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      s_ready_q  <= 1'b0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      core_rst_q <= 1'b1;
      core_din_q <= '0;
      now1_q     <= 1'b0;
      now2_q     <= 1'b0;
`ifdef SORT_STREAM_PERF_EN
      perf_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      crst_q     <= crst_d;
      ld_cnt_q   <= ld_cnt_d;
      out_cnt_q  <= out_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      s_ready_q  <= s_ready_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      core_rst_q <= core_rst_d;
      core_din_q <= core_din_d;
      now1_q     <= now1_d;
      now2_q     <= now2_d;
`ifdef SORT_STREAM_PERF_EN
      perf_q     <= perf_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = err_q;
  assign s_ready     = s_ready_q;
  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;
  assign core_rst    = core_rst_q;
  assign core_din    = core_din_q;
  assign core_now1   = now1_q;
  assign core_now2   = now2_q;
`ifdef SORT_STREAM_PERF_EN
  assign perf_cycles = perf_q;
`endif

endmodule

// File: doc/sort_stream_ctrl.md
Name: sort_stream_ctrl

Overview:
- Streaming front/back end for the sort accelerator core (`sort_top`).
- Replaces CPU-driven bit-banging of the core's MMIO control registers (rst, din, now1, now2, y_valid, dout) with a hardware sequencer.
- Flow per job: accept one `start`, pull exactly N = 2**LOG_INPUT_NUM words from a valid/ready input stream, feed them to the core, wait for the core's result, then drain the N sorted words onto a valid/ready output stream.
- Sits between the AXI memory peripheral (upstream source/sink) and the sort core (downstream).

Parameters:
- LOG_INPUT_NUM, 3: log2 of the element count per job; N = 2**LOG_INPUT_NUM.
- DATA_WIDTH, 32: element width in bits.
- TIMEOUT_CYCLES, 4096: maximum number of cycles spent in WAIT before an error is flagged; must be ≥ 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last output handshake.
- timeout_err  out  1  sticky error flag; cleared by the next accepted start.
- s_data  in  DATA_WIDTH  input element.
- s_valid  in  1  input element valid.
- s_ready  out  1  block can accept an input element.
- m_data  out  DATA_WIDTH  sorted output element.
- m_valid  out  1  output element valid.
- m_ready  in  1  sink accepts the output element.
- m_last  out  1  marks the Nth output element.
- core_rst  out  1  drives the core's rst.
- core_din  out  DATA_WIDTH  drives the core's din.
- core_now1  out  1  load strobe to the core.
- core_now2  out  1  advance strobe to the core.
- core_y_valid  in  1  core result ready.
- core_dout  in  DATA_WIDTH  core's current output element.

Behaviour:
Reset values (rst high):
- State IDLE; core_rst=1.
- All other outputs 0.
- All counters 0.

Core protocol (decided):
- core_din is sampled by the core on a cycle where core_now1=1.
- core_y_valid rises after N loads.
- A one-cycle core_now2 pulse advances core_dout to the next element; the new value is stable one cycle after the pulse.

States and transitions:
- IDLE
  - core_rst=1.
  - On start: clear timeout_err, clear counters, go to CRST.
- CRST
  - core_rst=1 for exactly 2 cycles, then go to LOAD.
- LOAD
  - core_rst=0; s_ready=1.
  - On s_valid && s_ready: core_din<=s_data, core_now1<=1 for one cycle, ld_cnt++.
  - Back-to-back accepts are allowed, giving one load per cycle.
  - After the Nth accept: s_ready drops the next cycle; go to WAIT.
  - ld_cnt is LOG_INPUT_NUM+1 bits wide and never wraps within a job.
- WAIT
  - If core_y_valid=1: go to CAP.
  - If TIMEOUT_CYCLES cycles elapse first: set timeout_err, go to ERR.
- CAP
  - m_data<=core_dout.
  - m_last<=(out_cnt==N-1).
  - Go to SEND.
- SEND
  - m_valid=1; m_data and m_last are held stable until the handshake.
  - On m_valid && m_ready: m_valid<=0, out_cnt++.
    - If this was the last element: done<=1 for one cycle, go to IDLE. No core_now2 is issued after the last element.
    - Otherwise: go to ADV.
- ADV
  - core_now2=1 for one cycle, then go to CAP.
  - Output throughput is therefore 1 element per 3 cycles.
- ERR
  - core_rst=1; one cycle, then go to IDLE.
  - timeout_err stays set.

Boundary conditions:
- start while busy: ignored, no effect.
- start and rst asserted together: reset wins.
- s_valid outside LOAD: no effect; s_ready=0.
- m_ready outside SEND: no effect.
- rst mid-job: immediately return to IDLE with reset values.
  - Partial input is discarded.
  - No done pulse is generated.
- core_y_valid dropping during CAP/SEND/ADV: ignored; the drain continues.
- s_ready and m_valid are never high in the same cycle.
- core_now1 and core_now2 are never high in the same cycle.

Optional Feature:
Macro: SORT_STREAM_PERF_EN
- Defined:
  - Adds output port perf_cycles (32 bits, reset 0).
  - Cleared on an accepted start.
  - Increments every cycle while busy=1; saturates at 32'hFFFF_FFFF.
  - Holds its value in IDLE until the next start.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
1. Basic sort (LOG_INPUT_NUM=3, ascending core):
   - Stimulus: start, then stream 7,3,5,1,8,2,6,4 with s_valid held high and m_ready=1.
   - Required: m_data sequence 1..8; m_last only on 8; one done pulse; timeout_err=0.
2. Input backpressure:
   - Stimulus: s_valid toggles 1/0 each cycle.
   - Required: exactly 8 core_now1 pulses, each core_din equal to the accepted s_data; WAIT is entered only after the 8th accept.
3. Output stall:
   - Stimulus: m_ready=0 for 10 cycles during the 3rd element.
   - Required: m_valid stays high and m_data stable for those 10 cycles; no core_now2 until the handshake; all 8 outputs correct.
4. Timeout:
   - Stimulus: core stub that never asserts core_y_valid, TIMEOUT_CYCLES=16.
   - Required: timeout_err=1 after 16 WAIT cycles; core_rst=1 in ERR; back in IDLE; the next start clears timeout_err.
5. Reset mid-drain:
   - Stimulus: assert rst after the 4th output handshake.
   - Required: all outputs at reset values immediately; no done pulse; a fresh job then sorts correctly.
6. start while busy:
   - Stimulus: pulse start during LOAD.
   - Required: no state change and no counter clear. With SORT_STREAM_PERF_EN defined, case 1 with no stalls gives a fixed perf_cycles = 2 + 8 + WAIT cycles + 3×8 − 1, and the bench checks that exact value.
